// File: rtl/click_counter_display.sv
// Up/down BCD click counter driving a multiplexed, active-low 4-digit seven-segment display.
// Rising edges of add_click/sub_click step the count; digits are scanned every REFRESH_CYCLES clocks.
module click_counter_display #(
    parameter int unsigned REFRESH_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        add_click,
    input  logic        sub_click,
    output logic [15:0] count_bcd,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned CNT_W    = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned DIGITS   = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    // Active-low {g..a} pattern for one BCD digit; non-BCD codes blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic             add_prev_q, add_prev_d;
    logic             sub_prev_q, sub_prev_d;
    logic [15:0]      count_q, count_d;
    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q;

    logic             inc, dec;
    logic             carry, borrow;
    logic [3:0]       digit;
    logic [3:0]       digit_sel;

    always_comb begin
        add_prev_d = add_click;
        sub_prev_d = sub_click;
        inc        = add_click & ~add_prev_q;
        dec        = sub_click & ~sub_prev_q;
    end

    // Ripple carry/borrow digit by digit so every digit stays 0..9.
    always_comb begin
        count_d = count_q;
        carry   = inc & ~dec;
        borrow  = dec & ~inc;
        digit   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = digit + 4'd1;
                    carry             = 1'b0;
                end
            end else if (borrow) begin
                if (digit == 4'd0) begin
                    count_d[4*i +: 4] = 4'd9;
                end else begin
                    count_d[4*i +: 4] = digit - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
        sel_d         = sel_q;
        if (refresh_cnt_q == CNT_LAST) begin
            refresh_cnt_d = '0;
            sel_d         = sel_q + 2'd1;
        end
    end

    // Display follows the next digit index so an/seg switch together with sel.
    always_comb begin
        an_d      = 4'b1110;
        digit_sel = count_q[3:0];
        case (sel_d)
            2'd0: begin an_d = 4'b1110; digit_sel = count_q[3:0];   end
            2'd1: begin an_d = 4'b1101; digit_sel = count_q[7:4];   end
            2'd2: begin an_d = 4'b1011; digit_sel = count_q[11:8];  end
            2'd3: begin an_d = 4'b0111; digit_sel = count_q[15:12]; end
            default: begin an_d = 4'b1110; digit_sel = count_q[3:0]; end
        endcase
        seg_d = seg_decode(digit_sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_prev_q    <= 1'b1;
            sub_prev_q    <= 1'b1;
            count_q       <= 16'h0000;
            refresh_cnt_q <= '0;
            sel_q         <= 2'd0;
            an_q          <= 4'b1110;
            seg_q         <= 7'b1000000;
            dp_q          <= 1'b1;
        end else begin
            add_prev_q    <= add_prev_d;
            sub_prev_q    <= sub_prev_d;
            count_q       <= count_d;
            refresh_cnt_q <= refresh_cnt_d;
            sel_q         <= sel_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= 1'b1;
        end
    end

    assign count_bcd = count_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;

endmodule

// File: tb/tb_click_counter_display.sv
// Scoreboard bench for click_counter_display: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_click_counter_display;

    localparam int unsigned REFRESH = 4;
    localparam int unsigned SCAN    = 4 * REFRESH;

    logic        clk = 1'b0;
    logic        rst;
    logic        add_click;
    logic        sub_click;
    logic [15:0] count_bcd;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    click_counter_display #(.REFRESH_CYCLES(REFRESH)) dut (
        .clk       (clk),
        .rst       (rst),
        .add_click (add_click),
        .sub_click (sub_click),
        .count_bcd (count_bcd),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int          tag;
        bit          chk_cnt;
        logic [15:0] cnt;
        bit          chk_disp;
        logic [3:0]  an;
        logic [6:0]  seg;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          started = 1'b0;
    bit          drain_timeout = 1'b0;
    int          model = 0;
    int unsigned reset_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic push_cnt(input int unsigned c, input logic [15:0] v, input int tag);
        exp_t e;
        e.cyc = c; e.tag = tag; e.chk_cnt = 1'b1; e.cnt = v;
        e.chk_disp = 1'b0; e.an = 4'b0; e.seg = 7'b0;
        sb_q.push_back(e);
    endtask

    task automatic push_disp(input int unsigned c, input logic [3:0] a, input logic [6:0] s,
                             input int tag);
        exp_t e;
        e.cyc = c; e.tag = tag; e.chk_cnt = 1'b0; e.cnt = 16'h0;
        e.chk_disp = 1'b1; e.an = a; e.seg = s;
        sb_q.push_back(e);
    endtask

    // Monitor: invariant on an plus every queued expectation due this cycle.
    bit drain_reported = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            checks++;
            if ($countones(~an) != 1) begin
                errors++;
                $display("FAIL onehot_an cyc=%0d an=%b required exactly one low bit", cyc, an);
            end
        end
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc != cyc) begin
                checks++; errors++;
                $display("FAIL late_check tag=%0d due=%0d now=%0d", e.tag, e.cyc, cyc);
            end else begin
                if (e.chk_cnt) begin
                    checks++;
                    if (count_bcd !== e.cnt) begin
                        errors++;
                        $display("FAIL count tag=%0d cyc=%0d got=%h want=%h",
                                 e.tag, cyc, count_bcd, e.cnt);
                    end
                end
                if (e.chk_disp) begin
                    checks++;
                    if (an !== e.an || seg !== e.seg || dp !== 1'b1) begin
                        errors++;
                        $display("FAIL display tag=%0d cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                                 e.tag, cyc, an, seg, dp, e.an, e.seg);
                    end
                end
            end
        end
        if (drain_timeout && !drain_reported) begin
            drain_reported = 1'b1;
            checks++; errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int tag);
        rst = 1'b1; add_click = 1'b0; sub_click = 1'b0;
        tick();
        model = 0;
        reset_cyc = cyc;
        started = 1'b1;
        push_cnt(cyc, 16'h0000, tag);
        push_disp(cyc, 4'b1110, 7'b1000000, tag);
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_add(input int tag);
        push_cnt(cyc, to_bcd(model), tag);
        add_click = 1'b1;
        model = (model + 1) % 10000;
        push_cnt(cyc + 1, to_bcd(model), tag);
        tick();
        add_click = 1'b0;
        tick();
    endtask

    task automatic pulse_sub(input int tag);
        push_cnt(cyc, to_bcd(model), tag);
        sub_click = 1'b1;
        model = (model + 9999) % 10000;
        push_cnt(cyc + 1, to_bcd(model), tag);
        tick();
        sub_click = 1'b0;
        tick();
    endtask

    logic [3:0] an_tab  [4];
    logic [6:0] seg_tab [4];

    initial begin
        int unsigned c;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        // Digits of 1234 from ones upward: 4, 3, 2, 1.
        seg_tab[0] = 7'b0011001; seg_tab[1] = 7'b0110000;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b1111001;

        // 1: reset with add_click held high; no count until it falls and rises.
        rst = 1'b1; add_click = 1'b1; sub_click = 1'b0;
        tick(); tick();
        reset_cyc = cyc;
        started = 1'b1;
        push_cnt(cyc, 16'h0000, 10);
        push_disp(cyc, 4'b1110, 7'b1000000, 11);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            push_cnt(cyc, 16'h0000, 12);
        end
        add_click = 1'b0;
        tick();
        push_cnt(cyc, 16'h0000, 13);
        add_click = 1'b1;
        push_cnt(cyc + 1, 16'h0001, 14);
        tick();
        add_click = 1'b0;
        tick();

        // 2: increments with carry.
        do_reset(20);
        for (int i = 0; i < 10; i++) pulse_add(21);
        push_cnt(cyc, 16'h0010, 22);
        for (int i = 0; i < 990; i++) pulse_add(23);
        push_cnt(cyc, 16'h1000, 24);

        // 3: wrap and borrow.
        do_reset(30);
        for (int i = 0; i < 9999; i++) pulse_add(31);
        push_cnt(cyc, 16'h9999, 32);
        pulse_add(33);
        push_cnt(cyc, 16'h0000, 34);
        pulse_sub(35);
        push_cnt(cyc, 16'h9999, 36);
        pulse_add(37);
        for (int i = 0; i < 1000; i++) pulse_add(38);
        push_cnt(cyc, 16'h1000, 39);
        pulse_sub(40);
        push_cnt(cyc, 16'h0999, 41);

        // 4: simultaneous edges cancel.
        do_reset(50);
        for (int i = 0; i < 42; i++) pulse_add(51);
        push_cnt(cyc, 16'h0042, 52);
        add_click = 1'b1; sub_click = 1'b1;
        push_cnt(cyc + 1, 16'h0042, 53);
        tick();
        add_click = 1'b0; sub_click = 1'b0;
        tick();
        push_cnt(cyc, 16'h0042, 54);
        pulse_add(55);
        push_cnt(cyc, 16'h0043, 56);

        // 5: full display scan of 1234.
        do_reset(60);
        for (int i = 0; i < 1234; i++) pulse_add(61);
        push_cnt(cyc, 16'h1234, 62);
        c = cyc + 2;
        while ((c - reset_cyc) % SCAN != 0) c++;
        for (int k = 0; k <= 16; k++)
            push_disp(c + k, an_tab[(k / 4) % 4], seg_tab[(k / 4) % 4], 63);
        while (cyc < c + 17) tick();

        // 6: reset while digit 2 of 0567 is lit, with an add edge in the same cycle.
        do_reset(70);
        for (int i = 0; i < 567; i++) pulse_add(71);
        c = cyc + 1;
        while ((c - reset_cyc) % SCAN != 9) c++;
        while (cyc < c) tick();
        push_cnt(cyc, 16'h0567, 72);
        push_disp(cyc, 4'b1011, 7'b0010010, 73);
        rst = 1'b1; add_click = 1'b1;
        tick();
        rst = 1'b0;
        reset_cyc = cyc;
        for (int k = 0; k <= 4; k++) begin
            push_cnt(reset_cyc + k, 16'h0000, 74);
            push_disp(reset_cyc + k, (k < 4) ? 4'b1110 : 4'b1101, 7'b1000000, 75);
        end
        for (int i = 0; i < 6; i++) tick();
        add_click = 1'b0;
        tick();
        push_cnt(cyc, 16'h0000, 76);

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() > 0) drain_timeout = 1'b1;
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
